// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: byte-writable word RAM plus an MMIO window
// (LED, switches, timer, RAM write counter, numeric display), 1-cycle read latency.
module data_sram_responder #(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        sel,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   sw,
  output logic [31:0]       num
);

  typedef enum logic [13:0] {
    REG_LED   = 14'h0000,
    REG_SW    = 14'h0001,
    REG_TIMER = 14'h0002,
    REG_WRCNT = 14'h0003,
    REG_NUM   = 14'h0004
  } mmio_reg_e;

  logic [31:0]       mem [2**RAM_AW];

  logic [31:0]       rdata_q;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       num_q, num_d;
  logic [31:0]       timer_q, timer_d, timer_inc;
  logic [31:0]       wrcnt_q, wrcnt_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

  logic              mmio, ram_wr, mmio_wr, rd;
  logic [13:0]       off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       mmio_rdata;
  logic              unused_addr;

  assign unused_addr = ^addr[1:0];

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    mmio      = (addr[31:16] == MMIO_BASE[31:16]);
    off       = addr[15:2];
    ram_idx   = addr[RAM_AW+1:2];
    ram_wr    = en && we && !mmio && !rst;
    mmio_wr   = en && we && mmio && !rst;
    rd        = en && !we;
    timer_inc = timer_q + 32'd1;

    led_d   = led_q;
    num_d   = num_q;
    timer_d = timer_inc;
    wrcnt_d = wrcnt_q;

    if (ram_wr && (sel != 4'h0)) wrcnt_d = wrcnt_q + 32'd1;

    if (mmio_wr) begin
      case (off)
        REG_LED: begin
          for (int unsigned i = 0; i < LED_W; i++)
            if (sel[i/8]) led_d[i] = wdata[i];
        end
        // Write wins over the increment; unselected bytes still advance.
        REG_TIMER: timer_d = merge(timer_inc, wdata, sel);
        REG_NUM:   num_d   = merge(num_q, wdata, sel);
        default: ;
      endcase
    end

    mmio_rdata = '0;
    case (off)
      REG_LED:   mmio_rdata = 32'(led_q);
      REG_SW:    mmio_rdata = 32'(sw_sync_q);
      REG_TIMER: mmio_rdata = timer_q;
      REG_WRCNT: mmio_rdata = wrcnt_q;
      REG_NUM:   mmio_rdata = num_q;
      default:   mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_wr)
      for (int unsigned i = 0; i < 4; i++)
        if (sel[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      led_q     <= '0;
      num_q     <= '0;
      timer_q   <= '0;
      wrcnt_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      if (rd) rdata_q <= mmio ? mmio_rdata : mem[ram_idx];
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      wrcnt_q   <= wrcnt_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign rdata = rdata_q;
  assign led   = led_q;
  assign num   = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: reads push expected data, a monitor
// compares rdata on the cycle after each read strobe.
module tb_data_sram_responder;

  localparam logic [31:0] MB = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  sw = '0;
  logic [31:0] num;

  always #5 clk = ~clk;

  data_sram_responder #(
    .RAM_AW(12), .MMIO_BASE(32'hBFAF_0000), .LED_W(16), .SW_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .sel(sel), .addr(addr),
    .wdata(wdata), .rdata(rdata), .led(led), .sw(sw), .num(num)
  );

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a read sampled at an edge produces rdata by the following negedge.
  logic rd_v = 1'b0;
  always @(posedge clk) rd_v <= en && !we;

  always @(negedge clk) begin
    if (rd_v) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: got read data %h with no expected entry", rdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check(e.name, rdata, e.exp);
      end
    end
  end

  task automatic idle(input int unsigned n);
    en = 1'b0; we = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    en = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    en = 1'b1; we = 1'b0; addr = a; sel = 4'h0;
    sbq.push_back('{exp, name});
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", 32'(led), 32'h0);
    check("reset_num", num, 32'h0);

    wr(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    rd(32'h0000_0100, 32'hDEAD_BEEF, "ram_full_word");
    rd(MB + 32'hC, 32'd1, "wrcnt_one");

    wr(32'h0000_0100, 32'h1122_3344, 4'b0101);
    rd(32'h0000_0100, 32'hDE22_BE44, "ram_byte_merge");
    wr(32'h0000_0100, 32'hFFFF_FFFF, 4'h0);
    check("rdata_hold_after_write", rdata, 32'hDE22_BE44);
    rd(32'h0000_0100, 32'hDE22_BE44, "ram_sel_zero");
    rd(MB + 32'hC, 32'd2, "wrcnt_sel_zero");
    rd(32'h0000_4100, 32'hDE22_BE44, "ram_alias");
    idle(1);
    check("rdata_hold_idle", rdata, 32'hDE22_BE44);

    wr(MB, 32'h0000_FFFF, 4'hF);
    check("led_write", 32'(led), 32'h0000_FFFF);
    rd(MB + 32'h14, 32'h0, "mmio_unmapped");
    rd(MB, 32'h0000_FFFF, "led_read");
    rd(MB + 32'hC, 32'd2, "wrcnt_ignores_mmio");
    wr(MB, 32'h0000_1200, 4'b0010);
    check("led_partial", 32'(led), 32'h0000_12FF);

    wr(MB + 32'h10, 32'hCAFE_F00D, 4'hF);
    check("num_write", num, 32'hCAFE_F00D);
    rd(MB + 32'h10, 32'hCAFE_F00D, "num_read");

    wr(MB + 32'h8, 32'h0000_0010, 4'hF);
    idle(3);
    rd(MB + 32'h8, 32'h0000_0013, "timer_count");
    wr(MB + 32'h8, 32'hFFFF_FFFF, 4'hF);
    idle(1);
    rd(MB + 32'h8, 32'h0000_0000, "timer_wrap");
    wr(MB + 32'h8, 32'hAB00_0000, 4'b1000);
    rd(MB + 32'h8, 32'hAB00_0002, "timer_partial");

    sw = 8'hA5;
    idle(1);
    rd(MB + 32'h4, 32'h0000_0000, "sw_early");
    rd(MB + 32'h4, 32'h0000_00A5, "sw_synced");

    rst = 1'b1;
    rd(MB + 32'h8, 32'h0, "read_in_reset");
    wr(32'h0000_0100, 32'h0000_0000, 4'hF);
    rst = 1'b0;
    check("rst_led", 32'(led), 32'h0);
    check("rst_num", num, 32'h0);
    rd(MB + 32'h8, 32'h0, "rst_timer");
    rd(32'h0000_0100, 32'hDE22_BE44, "ram_kept_over_rst");
    rd(MB + 32'hC, 32'h0, "rst_wrcnt");

    idle(2);
    check("sb_drain", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Memory-side responder for the core's data SRAM port. It consumes en/we/sel/addr/wdata from the M stage and returns rdata one cycle later, in time for W-stage capture. It contains a byte-writable word RAM plus a small MMIO register window: LED, switches, a free-running timer, a RAM write counter and a numeric display register. It is the single data-side target on the SoC functional-test bus.

Parameters:
RAM_AW, 12, RAM word-address width; depth = 2^RAM_AW 32-bit words.
MMIO_BASE, 32'hBFAF_0000, MMIO window base; window is selected by addr[31:16] == MMIO_BASE[31:16].
LED_W, 16, width of the LED register/output.
SW_W, 8, width of the switch input.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  access strobe (read or write) this cycle
we  input  1  write when 1 (with en); read when 0
sel  input  4  byte enables; sel[i] covers wdata[8i+7:8i]
addr  input  32  byte address; addr[1:0] ignored
wdata  input  32  write data, already lane-aligned
rdata  output  32  read data, valid the cycle after a read
led  output  LED_W  LED register contents
sw  input  SW_W  asynchronous switch levels
num  output  32  numeric display register contents

Behaviour:
- Decode: mmio = (addr[31:16] == MMIO_BASE[31:16]). Otherwise the access goes to RAM word addr[RAM_AW+1:2]; higher RAM address bits alias.
- RAM write: en & we & ~mmio; write only the bytes whose sel bit is 1. sel = 0 writes nothing.
- RAM read: en & ~we & ~mmio. rdata <= mem[idx] at the clock edge, so latency is exactly 1 cycle.
- Read and write to the same word in the same cycle cannot happen on a single port. Back-to-back write then read of the same word returns the new data.
- rdata holds its last value in any cycle with en = 0 and after any write. It is not cleared.
- MMIO offsets (addr[15:0]):
  - 0x0000 LED: read/write, lower LED_W bits, per-byte sel.
  - 0x0004 SW: read-only, returns the synchronized sw zero-extended.
  - 0x0008 TIMER: read/write, per-byte sel.
  - 0x000C WRCNT: read-only.
  - 0x0010 NUM: read/write, per-byte sel.
  - Any other offset reads 0; writes to it are ignored.
  - MMIO reads are registered with the same 1-cycle latency as RAM.
- TIMER: increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0. A write in the same cycle wins: the selected bytes load wdata, unselected bytes load timer+1's corresponding bytes. Incrementing resumes the next cycle.
- A TIMER read returns the value before that cycle's increment.
- WRCNT: +1 on every RAM write with sel != 0. Wraps at 2^32. MMIO writes are not counted.
- SW: two-flop synchronizer. A switch change is visible on a read issued 2 cycles after the change.
- Reset (rst = 1 at an edge):
  - rdata, led, num, TIMER, WRCNT and the synchronizer flops go to 0.
  - RAM contents are not reset.
  - A read issued in the same cycle as rst is discarded: rdata = 0 the next cycle.
  - Writes while rst = 1 are ignored, for both RAM and MMIO.
- No stall/handshake output: every access completes in one cycle.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0100 (sel = 4'hF), read it back -> rdata = 0xDEADBEEF exactly one cycle after the read strobe; WRCNT = 1.
- Write 0x11223344 to 0x100 with sel = 4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44; sel = 0 write leaves the word unchanged and does not bump WRCNT.
- Write 0x0000_FFFF to MMIO_BASE+0x0 -> led = 16'hFFFF the next cycle; read of MMIO_BASE+0x14 -> 0; read of the LED register -> 0x0000FFFF.
- Write 0x0000_0010 to TIMER, then read it 3 cycles later -> 0x00000013. Load 0xFFFF_FFFF -> reads 0 one cycle later (wrap).
- Set sw = 8'hA5 -> a read of MMIO_BASE+0x4 issued 2 cycles later returns 0x000000A5; a read issued 1 cycle later returns the old value.
- Issue a read with rst = 1 in the same cycle -> rdata = 0 next cycle; led, num and TIMER = 0; prior RAM data at 0x100 still reads back unchanged after reset.
